seq_detect_frame_scheduler: RTL and testbench
=============================================

Name: seq_detect_frame_scheduler

Overview:
Shares one bit-serial Mealy sequence detector between two 4-bit word requesters.
- Arbitrates between the requesters round-robin.
- Clears the detector before each frame, then shifts the granted word in LSB-first, one bit per clock.
- Captures the detector's Mealy output on the last bit and returns a tagged match result over a valid/ready handshake.
- Sits between the producer logic and the detector instance.

Parameters:
FRAME_BITS, 4, bits per frame shifted into the detector; also the width of req*_data; must be ≥2.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a word
req0_data  in  FRAME_BITS  requester 0 word
req0_ready  out  1  requester 0 word accepted this cycle
req1_valid  in  1  requester 1 has a word
req1_data  in  FRAME_BITS  requester 1 word
req1_ready  out  1  requester 1 word accepted this cycle
det_rst_n  out  1  registered reset to the detector, active-low
det_in  out  1  registered serial bit to the detector
det_dec  in  1  detector Mealy output
res_valid  out  1  result available
res_match  out  1  1 = detector fired on the frame's last bit
res_src  out  1  requester index that owns the result
res_ready  in  1  result consumer accepts
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, det_rst_n=0, det_in=0, res_valid=0, res_match=0, res_src=0, busy=0, round-robin pointer favours req0.
- All outputs are registered except req*_ready and busy. Those two are decoded combinationally from state.
- States: IDLE, CLR, SHIFT, DONE.
- IDLE:
  - det_rst_n=1, det_in=0.
  - Grant goes to the valid requester. If both are valid, grant the one not granted last; the first contention after reset goes to req0.
  - reqN_ready = (state==IDLE) & grantN. At most one ready is high.
  - On valid&ready: latch the word into the shift register, latch src, update the pointer, go to CLR.
- CLR:
  - Exactly 1 cycle, with det_rst_n=0 and det_in=0.
  - Next state SHIFT with bit counter cnt=0. det_in presents data[0] in the first SHIFT cycle.
- SHIFT:
  - Lasts FRAME_BITS cycles. In cycle k, det_in = data[k] and det_rst_n=1.
  - det_dec is sampled only at the clock edge ending cycle k=FRAME_BITS-1, into res_match. det_dec is ignored at all other times.
  - Then go to DONE.
- DONE:
  - res_valid=1. res_match and res_src stay stable until res_ready.
  - On res_valid&res_ready: res_valid goes to 0 and the state goes to IDLE.
  - No new request is accepted while in DONE.
- Latency: the accept edge is followed by 1 CLR cycle and FRAME_BITS SHIFT cycles. res_valid rises at the (FRAME_BITS+2)th edge after accept.
- Throughput: with res_ready tied to 1, one frame per FRAME_BITS+3 cycles.
- Requesters must hold valid and data until ready. Data changes while waiting are taken as-is at grant.
- A single requester that is continuously valid is granted back-to-back; no bubble beyond the IDLE cycle.
- Reset mid-frame: all state clears asynchronously and det_rst_n drops to 0 immediately. The partial frame is discarded and no result is produced.
- res_ready high outside DONE has no effect.

Optional Feature:
Macro: SEQ_MATCH_CNT_EN
- Defined:
  - Adds output match_cnt [7:0], reset value 0.
  - Increments on each result handshake with res_match=1 and saturates at 255.
  - Adds input cnt_clr (1), a synchronous clear that wins over increment.
- Undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
The bench uses a stub detector that asserts det_dec only in the last SHIFT cycle of a frame whose LSB-first value is 4'h7. The stub's state is cleared by det_rst_n.
1. Reset release, then req0 valid with data 4'h7 and res_ready=1 -> req0_ready is high 1 cycle; det_rst_n is low 1 cycle; det_in is 1,1,1,0; res_valid rises 6 edges after accept with res_match=1 and res_src=0.
2. req1 sends data 4'h5 -> res_match=0 and res_src=1; det_dec pulses injected during SHIFT cycles 0-2 are ignored.
3. Both requesters valid continuously with data 4'h7 -> grants alternate 0,1,0,1; the first grant after reset is req0; 4 results arrive, all with match=1.
4. res_ready held at 0 for 5 cycles in DONE -> res_valid, res_match and res_src stay stable; no req*_ready is asserted until res_ready is taken high.
5. rst_n asserted in SHIFT cycle 2 -> all outputs return to reset values asynchronously and no res_valid follows. After release, a new 4'h7 frame still gives match=1.
6. With SEQ_MATCH_CNT_EN defined: 300 matching frames -> match_cnt=255; then cnt_clr -> 0. Non-matching frames do not increment.

Source files
------------

// File: rtl/seq_detect_frame_scheduler.sv
// Round-robin scheduler feeding 4-bit words LSB-first into a shared bit-serial Mealy detector.
// Optional SEQ_MATCH_CNT_EN adds a saturating match counter (match_cnt) with synchronous clear (cnt_clr).
module seq_detect_frame_scheduler #(
  parameter int FRAME_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef SEQ_MATCH_CNT_EN
  input  logic                  cnt_clr,
  output logic [7:0]            match_cnt,
`endif
  input  logic                  req0_valid,
  input  logic [FRAME_BITS-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [FRAME_BITS-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  det_rst_n,
  output logic                  det_in,
  input  logic                  det_dec,
  output logic                  res_valid,
  output logic                  res_match,
  output logic                  res_src,
  input  logic                  res_ready,
  output logic                  busy
);

  localparam int CW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   sh_q, sh_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    pref_q, pref_d;
  logic                    det_rst_n_q, det_rst_n_d;
  logic                    det_in_q, det_in_d;
  logic                    res_valid_q, res_valid_d;
  logic                    res_match_q, res_match_d;
  logic                    res_src_q, res_src_d;
  logic                    grant0, grant1;

  // pref_q=1 means req1 wins the next contention
  assign grant0     = req0_valid & (~req1_valid | ~pref_q);
  assign grant1     = req1_valid & (~req0_valid |  pref_q);
  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;
  assign busy       = (state_q != IDLE);

  assign det_rst_n  = det_rst_n_q;
  assign det_in     = det_in_q;
  assign res_valid  = res_valid_q;
  assign res_match  = res_match_q;
  assign res_src    = res_src_q;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    pref_d      = pref_q;
    det_rst_n_d = det_rst_n_q;
    det_in_d    = det_in_q;
    res_valid_d = res_valid_q;
    res_match_d = res_match_q;
    res_src_d   = res_src_q;
    case (state_q)
      IDLE: begin
        det_rst_n_d = 1'b1;
        det_in_d    = 1'b0;
        if (req0_ready | req1_ready) begin
          sh_d        = req1_ready ? req1_data : req0_data;
          res_src_d   = req1_ready;
          pref_d      = req0_ready;
          det_rst_n_d = 1'b0;
          state_d     = CLR;
        end
      end
      CLR: begin
        det_rst_n_d = 1'b1;
        det_in_d    = sh_q[0];
        sh_d        = sh_q >> 1;
        cnt_d       = '0;
        state_d     = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          // Only the edge closing the last bit carries a meaningful Mealy output
          res_match_d = det_dec;
          res_valid_d = 1'b1;
          det_in_d    = 1'b0;
          state_d     = DONE;
        end else begin
          det_in_d = sh_q[0];
          sh_d     = sh_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      pref_q      <= 1'b0;
      det_rst_n_q <= 1'b0;
      det_in_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
      res_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      pref_q      <= pref_d;
      det_rst_n_q <= det_rst_n_d;
      det_in_q    <= det_in_d;
      res_valid_q <= res_valid_d;
      res_match_q <= res_match_d;
      res_src_q   <= res_src_d;
    end
  end

`ifdef SEQ_MATCH_CNT_EN
  logic [7:0] match_cnt_q, match_cnt_d;

  assign match_cnt = match_cnt_q;

  always_comb begin
    match_cnt_d = match_cnt_q;
    if (cnt_clr)
      match_cnt_d = 8'd0;
    else if (res_valid_q & res_ready & res_match_q & (match_cnt_q != 8'hFF))
      match_cnt_d = match_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) match_cnt_q <= 8'd0;
    else        match_cnt_q <= match_cnt_d;
  end
`endif

endmodule

// File: tb/tb_seq_detect_frame_scheduler.sv
// Scoreboard bench for seq_detect_frame_scheduler with a stub detector that fires on LSB-first 4'h7.
module tb_seq_detect_frame_scheduler;
  localparam int FB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [FB-1:0] req0_data = 0, req1_data = 0;
  logic          det_rst_n, det_in, det_dec, res_valid, res_match, res_src, busy;
  logic          res_ready = 0;
`ifdef SEQ_MATCH_CNT_EN
  logic          cnt_clr = 0;
  logic [7:0]    match_cnt;
`endif

  seq_detect_frame_scheduler #(.FRAME_BITS(FB)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SEQ_MATCH_CNT_EN
    .cnt_clr(cnt_clr), .match_cnt(match_cnt),
`endif
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .det_rst_n(det_rst_n), .det_in(det_in), .det_dec(det_dec),
    .res_valid(res_valid), .res_match(res_match), .res_src(res_src),
    .res_ready(res_ready), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stub detector: collects bits since its reset, fires on the 4th bit if the word is 4'h7
  logic [FB-1:0] hist;
  int            nb;
  logic          inj = 1'b0;
  always @(posedge clk or negedge det_rst_n) begin
    if (!det_rst_n) begin
      hist <= '0;
      nb   <= 0;
    end else begin
      if (nb < FB) hist[nb] <= det_in;
      if (nb < 15) nb <= nb + 1;
    end
  end
  assign det_dec = ((nb == FB-1) && ({det_in, hist[FB-2:0]} == 4'h7)) || inj;

  // Reference model state
  typedef struct { logic src; logic m; } res_t;
  res_t          sb[$];
  int            srcs[$];
  logic          free, pend, pref, acc0, acc1;
  int            lat, nres = 0, mexp;
  logic [FB-1:0] cur;

  task automatic model_reset();
    free = 1; pend = 0; pref = 0; lat = 0; acc0 = 0; acc1 = 0; mexp = 0;
    sb.delete();
  endtask

  // Transaction-level model: one frame occupies the engine for FB+2 cycles, then waits for res_ready
  always @(negedge clk) begin
    logic g0, g1;
    if (rst_n) begin
      acc0 = 0; acc1 = 0;
      if (pend) begin free = 1; pend = 0; end
      if (!free) lat++;
      chk("busy", busy, !free);
      chk("res_valid", res_valid, (!free && lat >= FB+2));
      if (!free) begin
        if (lat == 1) begin
          chk("clr_det_rst_n", det_rst_n, 0);
          chk("clr_det_in", det_in, 0);
        end else if (lat <= FB+1) begin
          chk("shift_det_rst_n", det_rst_n, 1);
          chk("shift_det_in", det_in, cur[lat-2]);
        end else begin
          chk("done_det_rst_n", det_rst_n, 1);
        end
      end
      g0 = free && req0_valid && (!req1_valid || !pref);
      g1 = free && req1_valid && (!req0_valid || pref);
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      if (!free && res_valid && res_ready) pend = 1;
      if (g0 || g1) begin
        cur = g0 ? req0_data : req1_data;
        sb.push_back('{src: g1, m: (cur == 4'h7)});
        free = 0; lat = 0; pref = g0; acc0 = g0; acc1 = g1;
      end
    end
  end

  // Monitor: compares presented results against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      chk("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        chk("res_src", res_src, sb[0].src);
        chk("res_match", res_match, sb[0].m);
        if (res_ready) begin
          srcs.push_back(int'(res_src));
          void'(sb.pop_front());
          nres++;
        end
      end
    end
  end

`ifdef SEQ_MATCH_CNT_EN
  always @(negedge clk) begin
    if (rst_n) begin
      chk("match_cnt", match_cnt, mexp);
      if (cnt_clr) mexp = 0;
      else if (res_valid && res_ready && res_match && mexp < 255) mexp++;
    end
  end
`endif

  // Driver: 0 idle, 1 continuous fixed word, 2 random, 3 one-shot fixed word
  int            mode0 = 0, mode1 = 0, rr = 0;
  logic [FB-1:0] fix0 = 0, fix1 = 0;
  logic          inj_en = 0;
  always @(posedge clk) begin
    #1;
    if (mode0 == 0) req0_valid = 0;
    else if (acc0 || !req0_valid) begin
      if (mode0 == 3 && acc0) begin req0_valid = 0; mode0 = 0; end
      else if (mode0 == 2) begin
        req0_valid = ($urandom % 2) == 1;
        req0_data  = ($urandom % 3 == 0) ? 4'h7 : 4'($urandom);
      end else begin req0_valid = 1; req0_data = fix0; end
    end else if (mode0 == 2 && $urandom % 4 == 0) req0_data = 4'($urandom);

    if (mode1 == 0) req1_valid = 0;
    else if (acc1 || !req1_valid) begin
      if (mode1 == 3 && acc1) begin req1_valid = 0; mode1 = 0; end
      else if (mode1 == 2) begin
        req1_valid = ($urandom % 2) == 1;
        req1_data  = ($urandom % 3 == 0) ? 4'h7 : 4'($urandom);
      end else begin req1_valid = 1; req1_data = fix1; end
    end else if (mode1 == 2 && $urandom % 4 == 0) req1_data = 4'($urandom);

    case (rr)
      0:       res_ready = 0;
      1:       res_ready = 1;
      default: res_ready = ($urandom % 2) == 1;
    endcase
    inj = inj_en && (nb != FB-1) && ($urandom % 2 == 1);
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_det_rst_n"}, det_rst_n, 0);
    chk({tag, "_det_in"}, det_in, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_match"}, res_match, 0);
    chk({tag, "_res_src"}, res_src, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, {req0_ready, req1_ready}, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #2;
    mode0 = 0; mode1 = 0; req0_valid = 0; req1_valid = 0; inj_en = 0;
    rst_n = 0;
    model_reset();
    #1 chk_reset(tag);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
  endtask

  task automatic wait_nres(input int tgt, input int budget);
    int t = 0;
    while (nres < tgt && t < budget) begin @(negedge clk); #2; t++; end
    chk("result_timeout", (nres >= tgt), 1);
  endtask

  task automatic drain();
    int t = 0;
    while (!(free && sb.size() == 0 && !pend) && t < 200) begin @(negedge clk); #2; t++; end
    chk("drain_timeout", (free && sb.size() == 0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t;
    model_reset();
    do_reset("por");

    // Single matching frame from req0
    rr = 1; fix0 = 4'h7; mode0 = 3;
    wait_nres(nres + 1, 40);

    // Non-matching frame from req1 with stray det_dec pulses before the last bit
    inj_en = 1; fix1 = 4'h5; mode1 = 3;
    wait_nres(nres + 1, 40);
    inj_en = 0;
    drain();

    // Contention: grants must alternate starting at req0
    do_reset("rst_rr");
    srcs.delete();
    fix0 = 4'h7; fix1 = 4'h7; mode0 = 1; mode1 = 1; rr = 1;
    wait_nres(nres + 4, 80);
    mode0 = 0; mode1 = 0;
    for (int i = 0; i < 4; i++) chk("rr_order", srcs[i], i % 2);
    drain();

    // Back-pressure in DONE
    base = nres;
    rr = 0; fix0 = 4'h7; mode0 = 3;
    t = 0;
    while (!res_valid && t < 40) begin @(negedge clk); #2; t++; end
    chk("bp_res_valid_seen", res_valid, 1);
    fix1 = 4'h5; mode1 = 3;
    repeat (5) @(negedge clk);
    #2 chk("bp_still_valid", res_valid, 1);
    rr = 1;
    wait_nres(base + 2, 60);
    drain();

    // Asynchronous reset during SHIFT cycle 2
    rr = 1; fix0 = 4'h7; mode0 = 3;
    t = 0;
    while (!(!free && lat == 4) && t < 40) begin @(negedge clk); #2; t++; end
    chk("mid_reset_reached", (!free && lat == 4), 1);
    rst_n = 0;
    mode0 = 0; mode1 = 0;
    model_reset();
    #1 chk_reset("async");
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    repeat (8) @(negedge clk);
    fix0 = 4'h7; mode0 = 3;
    wait_nres(nres + 1, 40);
    drain();

    // Randomised traffic, back-pressure and stray detector pulses
    mode0 = 2; mode1 = 2; rr = 2; inj_en = 1;
    repeat (400) @(posedge clk);
    #2 mode0 = 0; mode1 = 0; inj_en = 0; rr = 1;
    drain();

`ifdef SEQ_MATCH_CNT_EN
    do_reset("rst_cnt");
    rr = 1; fix0 = 4'h7; mode0 = 1;
    wait_nres(nres + 300, 300 * 8 + 100);
    mode0 = 0;
    drain();
    chk("match_cnt_sat", match_cnt, 255);
    @(posedge clk); #2 cnt_clr = 1;
    @(posedge clk); #2 cnt_clr = 0;
    @(negedge clk); #2 chk("match_cnt_clr", match_cnt, 0);
    fix0 = 4'h5; mode0 = 1;
    wait_nres(nres + 3, 40);
    mode0 = 0;
    drain();
    chk("match_cnt_nomatch", match_cnt, 0);
    fix0 = 4'h7; mode0 = 3;
    wait_nres(nres + 1, 40);
    drain();
    chk("match_cnt_one", match_cnt, 1);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
